// File: rtl/instruction_execute_stage.sv
// rtl/instruction_execute_stage.sv - MIPS32 execute stage with forwarding, ALU decode and EX/MEM register
module instruction_execute_stage #(
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic [4:0]         i_rs,
  input  logic [4:0]         i_rt,
  input  logic [4:0]         i_rd,
  input  logic [NB_DATA-1:0] i_reg_DA,
  input  logic [NB_DATA-1:0] i_reg_DB,
  input  logic [NB_DATA-1:0] i_immediate,
  input  logic [5:0]         i_opcode,
  input  logic [4:0]         i_shamt,
  input  logic [5:0]         i_func,
  input  logic [15:0]        i_addr,
  input  logic               i_jump,
  input  logic               i_branch,
  input  logic               i_regDst,
  input  logic               i_mem2Reg,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_immediate_flag,
  input  logic               i_regWrite,
  input  logic [1:0]         i_aluSrc,
  input  logic [1:0]         i_aluOP,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [1:0]         i_fw_a,
  input  logic [1:0]         i_fw_b,
  output logic               o_mem2reg,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_regWrite,
  output logic               o_jump,
  output logic               o_sign_flag,
  output logic [1:0]         o_aluSrc,
  output logic [1:0]         o_width,
  output logic [1:0]         o_aluOP,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_data4Mem,
  output logic [NB_DATA-1:0] o_result
);

  localparam int NB_PAD = NB_DATA - 16;
  localparam logic [5:0] OP_JAL = 6'b000011;

  logic [NB_DATA-1:0] r_prev_result;
  logic [NB_DATA-1:0] w_fwd_a;
  logic [NB_DATA-1:0] w_fwd_b;
  logic [NB_DATA-1:0] w_op_b;
  logic [NB_DATA-1:0] w_imm_zext;
  logic [NB_DATA-1:0] w_link;
  logic [NB_DATA-1:0] w_alu_result;
  logic [4:0]         w_write_reg;
  logic               w_slt;
  logic               w_sltu;
  logic               w_unused;

  // Branch target and rs are resolved in decode; they only pass through here.
  assign w_unused = ^{i_branch, i_rs};

  always_comb begin
    w_fwd_a = i_reg_DA;
    w_fwd_b = i_reg_DB;
    case (i_fw_a)
      2'b01:   w_fwd_a = o_result;
      2'b10:   w_fwd_a = r_prev_result;
      default: w_fwd_a = i_reg_DA;
    endcase
    case (i_fw_b)
      2'b01:   w_fwd_b = o_result;
      2'b10:   w_fwd_b = r_prev_result;
      default: w_fwd_b = i_reg_DB;
    endcase
  end

  assign w_op_b     = i_immediate_flag ? i_immediate : w_fwd_b;
  assign w_imm_zext = {{NB_PAD{1'b0}}, i_immediate[15:0]};
  assign w_link     = {{NB_PAD{1'b0}}, i_addr};
  assign w_slt      = $signed(w_fwd_a) < $signed(w_op_b);
  assign w_sltu     = w_fwd_a < w_op_b;

  always_comb begin
    w_alu_result = '0;
    case (i_aluOP)
      2'b00: w_alu_result = w_fwd_a + w_op_b;
      2'b01: w_alu_result = w_fwd_a - w_op_b;
      2'b10: begin
        case (i_func)
          6'b100000, 6'b100001: w_alu_result = w_fwd_a + w_op_b;
          6'b100010, 6'b100011: w_alu_result = w_fwd_a - w_op_b;
          6'b100100: w_alu_result = w_fwd_a & w_op_b;
          6'b100101: w_alu_result = w_fwd_a | w_op_b;
          6'b100110: w_alu_result = w_fwd_a ^ w_op_b;
          6'b100111: w_alu_result = ~(w_fwd_a | w_op_b);
          6'b101010: w_alu_result = {{(NB_DATA-1){1'b0}}, w_slt};
          6'b101011: w_alu_result = {{(NB_DATA-1){1'b0}}, w_sltu};
          6'b000000: w_alu_result = w_op_b << i_shamt;
          6'b000010: w_alu_result = w_op_b >> i_shamt;
          6'b000011: w_alu_result = $signed(w_op_b) >>> i_shamt;
          6'b000100: w_alu_result = w_op_b << w_fwd_a[4:0];
          6'b000110: w_alu_result = w_op_b >> w_fwd_a[4:0];
          6'b000111: w_alu_result = $signed(w_op_b) >>> w_fwd_a[4:0];
          6'b001001: w_alu_result = w_link;
          default:   w_alu_result = '0;
        endcase
      end
      default: begin
        case (i_opcode)
          6'b001010: w_alu_result = {{(NB_DATA-1){1'b0}}, w_slt};
          6'b001011: w_alu_result = {{(NB_DATA-1){1'b0}}, w_sltu};
          6'b001100: w_alu_result = w_fwd_a & w_imm_zext;
          6'b001101: w_alu_result = w_fwd_a | w_imm_zext;
          6'b001110: w_alu_result = w_fwd_a ^ w_imm_zext;
          6'b001111: w_alu_result = {i_immediate[15:0], {NB_PAD{1'b0}}};
          default:   w_alu_result = w_fwd_a + w_op_b;
        endcase
      end
    endcase
    // jal writes the link address no matter how decode set aluOP.
    if (i_opcode == OP_JAL) w_alu_result = w_link;
  end

  assign w_write_reg = (i_opcode == OP_JAL) ? 5'd31 : (i_regDst ? i_rd : i_rt);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_mem2reg     <= 1'b0;
      o_memRead     <= 1'b0;
      o_memWrite    <= 1'b0;
      o_regWrite    <= 1'b0;
      o_jump        <= 1'b0;
      o_sign_flag   <= 1'b0;
      o_aluSrc      <= 2'b00;
      o_width       <= 2'b00;
      o_aluOP       <= 2'b00;
      o_write_reg   <= 5'd0;
      o_data4Mem    <= '0;
      o_result      <= '0;
      r_prev_result <= '0;
    end else if (!i_stall && !i_halt) begin
      o_mem2reg     <= i_mem2Reg;
      o_memRead     <= i_memRead;
      o_memWrite    <= i_memWrite;
      o_regWrite    <= i_regWrite;
      o_jump        <= i_jump;
      o_sign_flag   <= i_sign_flag;
      o_aluSrc      <= i_aluSrc;
      o_width       <= i_width;
      o_aluOP       <= i_aluOP;
      o_write_reg   <= w_write_reg;
      o_data4Mem    <= w_fwd_b;
      o_result      <= w_alu_result;
      r_prev_result <= o_result;
    end
  end

endmodule

// File: tb/tb_instruction_execute_stage.sv
// tb/tb_instruction_execute_stage.sv - randomized and directed bench for instruction_execute_stage
module tb_instruction_execute_stage;

  logic        clk = 1'b0;
  logic        i_rst, i_stall, i_halt;
  logic [4:0]  i_rs, i_rt, i_rd, i_shamt;
  logic [31:0] i_reg_DA, i_reg_DB, i_immediate;
  logic [5:0]  i_opcode, i_func;
  logic [15:0] i_addr;
  logic        i_jump, i_branch, i_regDst, i_mem2Reg, i_memRead, i_memWrite;
  logic        i_immediate_flag, i_regWrite, i_sign_flag;
  logic [1:0]  i_aluSrc, i_aluOP, i_width, i_fw_a, i_fw_b;
  logic        o_mem2reg, o_memRead, o_memWrite, o_regWrite, o_jump, o_sign_flag;
  logic [1:0]  o_aluSrc, o_width, o_aluOP;
  logic [4:0]  o_write_reg;
  logic [31:0] o_data4Mem, o_result;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what the EX/MEM register and MEM/WB value should hold.
  logic [31:0] m_result, m_prev, m_data;
  logic [4:0]  m_wreg;
  logic [14:0] m_ctrl;
  logic [14:0] w_ctrl;

  assign w_ctrl = {o_mem2reg, o_memRead, o_memWrite, o_regWrite, o_jump, o_sign_flag,
                   o_aluSrc, o_width, o_aluOP, 3'b000};

  always #5 clk = ~clk;

  instruction_execute_stage #(.NB_DATA(32)) dut (
    .clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_halt(i_halt),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .i_reg_DA(i_reg_DA), .i_reg_DB(i_reg_DB), .i_immediate(i_immediate),
    .i_opcode(i_opcode), .i_shamt(i_shamt), .i_func(i_func), .i_addr(i_addr),
    .i_jump(i_jump), .i_branch(i_branch), .i_regDst(i_regDst), .i_mem2Reg(i_mem2Reg),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_immediate_flag(i_immediate_flag),
    .i_regWrite(i_regWrite), .i_aluSrc(i_aluSrc), .i_aluOP(i_aluOP), .i_width(i_width),
    .i_sign_flag(i_sign_flag), .i_fw_a(i_fw_a), .i_fw_b(i_fw_b),
    .o_mem2reg(o_mem2reg), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
    .o_regWrite(o_regWrite), .o_jump(o_jump), .o_sign_flag(o_sign_flag),
    .o_aluSrc(o_aluSrc), .o_width(o_width), .o_aluOP(o_aluOP),
    .o_write_reg(o_write_reg), .o_data4Mem(o_data4Mem), .o_result(o_result)
  );

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val);
    if (sel == 2'd1) return m_result;
    if (sel == 2'd2) return m_prev;
    return reg_val;
  endfunction

  function automatic logic [31:0] bool32(input bit b);
    return b ? 32'd1 : 32'd0;
  endfunction

  // Instruction semantics taken straight from the ISA description.
  function automatic logic [31:0] model_result();
    logic [31:0] a, b, zimm;
    longint sa, sb;
    a    = pick(i_fw_a, i_reg_DA);
    b    = i_immediate_flag ? i_immediate : pick(i_fw_b, i_reg_DB);
    zimm = {16'h0, i_immediate[15:0]};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    if (i_opcode == 6'o03) return {16'h0, i_addr};
    case (i_aluOP)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: case (i_func)
        6'o40, 6'o41: return a + b;
        6'o42, 6'o43: return a - b;
        6'o44: return a & b;
        6'o45: return a | b;
        6'o46: return a ^ b;
        6'o47: return ~(a | b);
        6'o52: return bool32(sa < sb);
        6'o53: return bool32({32'h0, a} < {32'h0, b});
        6'o00: return b << i_shamt;
        6'o02: return b >> i_shamt;
        6'o03: return 32'(sb >>> i_shamt);
        6'o04: return b << a[4:0];
        6'o06: return b >> a[4:0];
        6'o07: return 32'(sb >>> a[4:0]);
        6'o11: return {16'h0, i_addr};
        default: return 32'h0;
      endcase
      default: case (i_opcode)
        6'o12: return bool32(sa < sb);
        6'o13: return bool32({32'h0, a} < {32'h0, b});
        6'o14: return a & zimm;
        6'o15: return a | zimm;
        6'o16: return a ^ zimm;
        6'o17: return {i_immediate[15:0], 16'h0};
        default: return a + b;
      endcase
    endcase
  endfunction

  task automatic clear_inputs();
    {i_rst, i_stall, i_halt, i_rs, i_rt, i_rd, i_shamt} = '0;
    {i_reg_DA, i_reg_DB, i_immediate, i_opcode, i_func, i_addr} = '0;
    {i_jump, i_branch, i_regDst, i_mem2Reg, i_memRead, i_memWrite} = '0;
    {i_immediate_flag, i_regWrite, i_sign_flag} = '0;
    {i_aluSrc, i_aluOP, i_width, i_fw_a, i_fw_b} = '0;
  endtask

  // Advance one clock, updating the reference alongside the DUT.
  task automatic step();
    logic [31:0] n_result, n_data;
    logic [4:0]  n_wreg;
    n_result = model_result();
    n_data   = pick(i_fw_b, i_reg_DB);
    n_wreg   = (i_opcode == 6'o03) ? 5'd31 : (i_regDst ? i_rd : i_rt);
    @(posedge clk);
    if (i_rst) begin
      m_result = 0; m_prev = 0; m_data = 0; m_wreg = 0; m_ctrl = 0;
    end else if (!i_stall && !i_halt) begin
      m_prev   = m_result;
      m_result = n_result;
      m_data   = n_data;
      m_wreg   = n_wreg;
      m_ctrl   = {i_mem2Reg, i_memRead, i_memWrite, i_regWrite, i_jump, i_sign_flag,
                  i_aluSrc, i_width, i_aluOP, 3'b000};
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst = 1; i_reg_DA = 32'h1234; i_reg_DB = 32'h55; i_rt = 5'd3; i_memRead = 1;
    i_regWrite = 1; i_width = 2'd2; i_aluOP = 2'd0;
    step();
    vectors++;
    if (o_result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 0", o_result); end
    vectors++;
    if ({o_write_reg, o_data4Mem, w_ctrl} !== '0)
      begin miscompares++; $display("FAIL reset_misc got %h %h %h want 0", o_write_reg, o_data4Mem, w_ctrl); end
    i_rst = 0;
    step();
    vectors++;
    if (o_result !== 32'h1289 || o_write_reg !== 5'd3 || o_memRead !== 1'b1 || o_width !== 2'd2)
      begin miscompares++; $display("FAIL reset_release got %h %0d %b %0d want 1289 3 1 2", o_result, o_write_reg, o_memRead, o_width); end
  endtask

  task automatic test_rtype_add();
    clear_inputs();
    i_reg_DA = 10; i_reg_DB = 5; i_func = 6'b100000; i_aluOP = 2'b10; i_rt = 5'd7; i_rd = 5'd9;
    step();
    vectors++;
    if (o_result !== 32'd15 || o_write_reg !== 5'd7)
      begin miscompares++; $display("FAIL rtype_add got %0d rd%0d want 15 rd7", o_result, o_write_reg); end
    i_regDst = 1;
    step();
    vectors++;
    if (o_write_reg !== 5'd9) begin miscompares++; $display("FAIL regdst got %0d want 9", o_write_reg); end
  endtask

  task automatic test_addi();
    clear_inputs();
    i_reg_DA = 32'hF0; i_immediate = 32'h0F; i_immediate_flag = 1; i_opcode = 6'b001000;
    i_aluOP = 2'b11; i_reg_DB = 1;
    step();
    vectors++;
    if (o_result !== 32'hFF || o_data4Mem !== 32'h1)
      begin miscompares++; $display("FAIL addi got %h %h want ff 1", o_result, o_data4Mem); end
  endtask

  task automatic test_compare_shift();
    clear_inputs();
    i_reg_DA = 32'hFFFFFFFF; i_reg_DB = 1; i_aluOP = 2'b10; i_func = 6'b101010;
    step();
    vectors++;
    if (o_result !== 32'd1) begin miscompares++; $display("FAIL slt got %h want 1", o_result); end
    i_func = 6'b101011;
    step();
    vectors++;
    if (o_result !== 32'd0) begin miscompares++; $display("FAIL sltu got %h want 0", o_result); end
    i_reg_DB = 32'h80000000; i_shamt = 5'd4; i_func = 6'b000011;
    step();
    vectors++;
    if (o_result !== 32'hF8000000) begin miscompares++; $display("FAIL sra got %h want f8000000", o_result); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    i_reg_DA = 10; i_reg_DB = 5; i_aluOP = 2'b10; i_func = 6'b100000;
    step();
    i_fw_a = 2'b01; i_reg_DA = 0; i_reg_DB = 1;
    step();
    vectors++;
    if (o_result !== 32'd16) begin miscompares++; $display("FAIL fwd_exmem got %0d want 16", o_result); end
    i_fw_a = 2'b10;
    step();
    vectors++;
    if (o_result !== 32'd16) begin miscompares++; $display("FAIL fwd_memwb got %0d want 16", o_result); end
    i_fw_a = 2'b00; i_fw_b = 2'b10; i_reg_DA = 100;
    step();
    vectors++;
    if (o_result !== 32'd116 || o_data4Mem !== 32'd16)
      begin miscompares++; $display("FAIL fwd_b got %0d %0d want 116 16", o_result, o_data4Mem); end
  endtask

  task automatic test_stall_halt();
    clear_inputs();
    i_reg_DA = 7; i_reg_DB = 8; i_rt = 5'd4;
    step();
    i_reg_DA = 99; i_rt = 5'd12; i_memWrite = 1; i_stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (o_result !== 32'd15 || o_write_reg !== 5'd4 || o_memWrite !== 1'b0)
        begin miscompares++; $display("FAIL stall cyc%0d got %0d %0d %b want 15 4 0", k, o_result, o_write_reg, o_memWrite); end
    end
    i_stall = 0; i_halt = 1;
    step();
    vectors++;
    if (o_result !== 32'd15) begin miscompares++; $display("FAIL halt got %0d want 15", o_result); end
    i_rst = 1;
    step();
    vectors++;
    if (o_result !== 32'd0) begin miscompares++; $display("FAIL rst_over_halt got %0d want 0", o_result); end
    i_rst = 0; i_halt = 0;
    step();
    vectors++;
    if (o_result !== 32'd107 || o_write_reg !== 5'd12)
      begin miscompares++; $display("FAIL unstall got %0d %0d want 107 12", o_result, o_write_reg); end
  endtask

  task automatic test_jal();
    clear_inputs();
    i_opcode = 6'b000011; i_addr = 16'h0040; i_reg_DA = 32'h777; i_regDst = 1; i_rd = 5'd2;
    step();
    vectors++;
    if (o_result !== 32'h40 || o_write_reg !== 5'd31)
      begin miscompares++; $display("FAIL jal got %h %0d want 40 31", o_result, o_write_reg); end
  endtask

  task automatic test_random();
    logic [5:0] funcs [16] = '{6'o40, 6'o41, 6'o42, 6'o43, 6'o44, 6'o45, 6'o46, 6'o47,
                               6'o52, 6'o53, 6'o00, 6'o02, 6'o03, 6'o04, 6'o06, 6'o07};
    logic [5:0] ops [12] = '{6'o10, 6'o11, 6'o12, 6'o13, 6'o14, 6'o15, 6'o16, 6'o17,
                             6'o03, 6'o43, 6'o53, 6'o04};
    for (int n = 0; n < 400; n++) begin
      i_rst    = ($urandom_range(0, 29) == 0);
      i_stall  = ($urandom_range(0, 9) == 0);
      i_halt   = ($urandom_range(0, 9) == 0);
      i_reg_DA = $urandom; i_reg_DB = $urandom;
      i_immediate = (($urandom & 1) != 0) ? 32'($signed($urandom_range(0, 65535) - 32768)) : 32'h0000_0000 | $urandom_range(0, 65535);
      i_rs = 5'($urandom); i_rt = 5'($urandom); i_rd = 5'($urandom); i_shamt = 5'($urandom);
      i_func   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 15)];
      if ($urandom_range(0, 15) == 0) i_func = 6'o11;
      i_opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      i_addr   = 16'($urandom);
      {i_jump, i_branch, i_regDst, i_mem2Reg, i_memRead, i_memWrite} = 6'($urandom);
      {i_immediate_flag, i_regWrite, i_sign_flag} = 3'($urandom);
      {i_aluSrc, i_aluOP, i_width, i_fw_a, i_fw_b} = 10'($urandom);
      step();
      vectors++;
      if (o_result !== m_result) begin miscompares++; $display("FAIL rnd_result n%0d got %h want %h", n, o_result, m_result); end
      vectors++;
      if (o_write_reg !== m_wreg) begin miscompares++; $display("FAIL rnd_wreg n%0d got %0d want %0d", n, o_write_reg, m_wreg); end
      vectors++;
      if (o_data4Mem !== m_data) begin miscompares++; $display("FAIL rnd_data n%0d got %h want %h", n, o_data4Mem, m_data); end
      vectors++;
      if (w_ctrl !== m_ctrl) begin miscompares++; $display("FAIL rnd_ctrl n%0d got %h want %h", n, w_ctrl, m_ctrl); end
    end
  endtask

  initial begin
    m_result = 0; m_prev = 0; m_data = 0; m_wreg = 0; m_ctrl = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_rtype_add();
    test_addi();
    test_compare_shift();
    test_forwarding();
    test_stall_halt();
    test_jal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_execute_stage.md
Name: instruction_execute_stage

Overview:
Execute (EX) stage of the 5-stage MIPS32 pipeline, including the EX/MEM pipeline register.
- Selects operands through forwarding muxes and decodes the ALU operation from aluOP, func and opcode.
- Computes the result and selects the destination register.
- Registers the result, the store data and the MEM/WB control bits for the memory stage.

Parameters:
NB_DATA, 32, datapath width (the spec is written for 32).

Ports:
clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_stall  in  1  hold EX/MEM register
i_halt  in  1  hold EX/MEM register (program halted)
i_rs, i_rt, i_rd  in  5 each  register specifiers
i_reg_DA, i_reg_DB  in  NB_DATA each  register-file read data (rs, rt)
i_immediate  in  NB_DATA  sign-extended immediate from decode
i_opcode  in  6  instruction opcode
i_shamt  in  5  shift amount
i_func  in  6  R-type function code
i_addr  in  16  link (return) address precomputed by decode
i_jump, i_branch, i_regDst, i_mem2Reg, i_memRead, i_memWrite, i_immediate_flag, i_regWrite  in  1 each  control bits
i_aluSrc, i_aluOP, i_width  in  2 each  control fields
i_sign_flag  in  1  load sign-extension select
i_fw_a, i_fw_b  in  2 each  forwarding selects for operands A and B
o_mem2reg, o_memRead, o_memWrite, o_regWrite, o_jump, o_sign_flag  out  1 each  registered control bits
o_aluSrc, o_width, o_aluOP  out  2 each  registered control fields
o_write_reg  out  5  registered destination register
o_data4Mem  out  NB_DATA  registered store data
o_result  out  NB_DATA  registered ALU / link result

Behaviour:
- Reset: when i_rst=1 at a rising edge, every output clears to 0. The internal previous-result register also clears to 0.
- Forwarding, operand A from i_fw_a (operand B from i_fw_b uses the same codes):
  - 00 or 11: i_reg_DA
  - 01: current o_result (EX/MEM value)
  - 10: prev_result, the value o_result held before its last update (MEM/WB value)
- Store data: fwdB.
- Operand B: i_immediate if i_immediate_flag=1, else fwdB.
- i_aluOP = 00: ADD, for load/store address generation.
- i_aluOP = 01: SUB, for branch compare.
- i_aluOP = 10: decode i_func.
  - 100000/100001: add
  - 100010/100011: sub
  - 100100: and
  - 100101: or
  - 100110: xor
  - 100111: nor
  - 101010: signed slt
  - 101011: unsigned sltu
  - 000000: sll B by shamt
  - 000010: srl B by shamt
  - 000011: sra B by shamt
  - 000100/000110/000111: sllv/srlv/srav B by A[4:0]
  - 001001 (jalr): result = {16'b0, i_addr}
  - any other func: result 0
- i_aluOP = 11: decode i_opcode.
  - 001000/001001: add
  - 001010: slti, signed
  - 001011: sltiu, unsigned
  - 001100/001101/001110: and/or/xor, with B = zero-extended i_immediate[15:0]
  - 001111 (lui): {i_immediate[15:0], 16'b0}
  - any other opcode: add
- Opcode 000011 (jal), regardless of aluOP: result = {16'b0, i_addr}.
- Arithmetic is modulo 2^32; overflow is ignored and no trap is raised.
- Set-less-than results are 0 or 1.
- o_write_reg:
  - 31 if opcode = 000011
  - else i_rd if i_regDst=1
  - else i_rt
- Register update, latency 1 cycle: if !i_rst and !i_stall and !i_halt, all outputs load their next values and prev_result <= o_result.
- Control passthrough: o_mem2reg <= i_mem2Reg. Likewise memRead, memWrite, regWrite, aluSrc, jump, sign_flag, width and aluOP copy their inputs.
- i_branch, i_rs and i_shamt (outside shifts) have no other effect.
- Stall or halt: all outputs and prev_result hold their values; reset has priority over both.

Test Plan:
- Reset: i_rst=1 for one edge with nonzero inputs -> all outputs 0. Deassert: first edge after that loads the inputs.
- R-type add: DA=10, DB=5, func=100000, aluOP=10, fw=00 -> o_result=15 one edge later; o_write_reg=i_rt when regDst=0.
- ADDI: DA=0xF0, imm=0x0F, immediate_flag=1, opcode=001000, aluOP=11 -> o_result=0x000000FF; o_data4Mem=0x00000001 with DB=1.
- Signed compare: DA=0xFFFFFFFF, DB=1, func=101010 -> result 1; func=101011 -> result 0. Also sra of 0x80000000 by shamt 4 -> 0xF8000000.
- Forwarding: execute an ADD giving 15, then fw_a=01, DA=0, DB=1 -> result 16. Next cycle, fw_a=10 -> uses 15.
- Stall/halt: i_stall=1 with new inputs -> outputs unchanged for the stall duration. JAL (opcode 000011, i_addr=0x0040) -> o_result=0x40, o_write_reg=31.
